// File: rtl/matrix_scan_driver.sv
// rtl/matrix_scan_driver.sv - double-buffered, row-scanned LED matrix shift-register driver
//
// Scans ROWS x COLS pixels out to the row and column shift registers, one row at a time.
// Game logic writes whole rows into the back bank. The front and back banks swap only at a frame boundary.
//
// Ports:
//   clk32mhz, reset_n      system clock and asynchronous active-low reset
//   wr_en/wr_row/wr_data   back-bank row write (out-of-range rows ignored)
//   swap_req/swap_ack      swap request (sticky until served) and one-cycle completion pulse
//   brightness             global brightness, sampled once per row in LATCH
//   frame_start            one-cycle pulse in the LATCH cycle of row 0
//   RCLK/RSDI              row shift-register clock and data
//   CCLK/CSDI/LE           column shift-register clock, data and latch enable
//   OEB                    active-low output enable, PWM'd during DISPLAY
module matrix_scan_driver #(
    parameter int ROWS             = 16,
    parameter int COLS             = 16,
    parameter int SCREENTIMERWIDTH = 10,
    parameter int BRIGHT_BITS      = 3
) (
    input  logic                      clk32mhz,
    input  logic                      reset_n,
    input  logic                      wr_en,
    input  logic [$clog2(ROWS)-1:0]   wr_row,
    input  logic [COLS-1:0]           wr_data,
    input  logic                      swap_req,
    output logic                      swap_ack,
    input  logic [BRIGHT_BITS-1:0]    brightness,
    output logic                      frame_start,
    output logic                      RCLK,
    output logic                      RSDI,
    output logic                      CCLK,
    output logic                      CSDI,
    output logic                      LE,
    output logic                      OEB
);
    localparam int RW        = $clog2(ROWS);
    localparam int CIW       = $clog2(COLS);
    localparam int SHIFT_LEN = 2 * COLS;
    localparam int DISP_LEN  = 1 << SCREENTIMERWIDTH;
    localparam int MAX_LEN   = (SHIFT_LEN > DISP_LEN) ? SHIFT_LEN : DISP_LEN;
    localparam int CNT_W     = $clog2(MAX_LEN) + 1;
    localparam int ON_W      = SCREENTIMERWIDTH + 1;

    typedef enum logic [1:0] {ST_SHIFT, ST_ROW, ST_LATCH, ST_DISPLAY} state_t;

    state_t                              state_q, state_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [RW-1:0]                       row_q, row_d;
    logic                                started_q, started_d;
    logic                                front_q, front_d;
    logic                                pending_q, pending_d;
    logic [BRIGHT_BITS-1:0]              bright_q, bright_d;
    logic [1:0][ROWS-1:0][COLS-1:0]      mem_q, mem_d;
    logic rclk_q, rclk_d, rsdi_q, rsdi_d, cclk_q, cclk_d, csdi_q, csdi_d;
    logic le_q, le_d, oeb_q, oeb_d, ack_q, ack_d, fs_q, fs_d;
    logic [ON_W-1:0]                     on_time;
    logic [CIW-1:0]                      col_idx;
    logic [31:0]                         wr_row_ext;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        started_d  = started_q;
        front_d    = front_q;
        bright_d   = bright_q;
        mem_d      = mem_q;
        ack_d      = 1'b0;
        pending_d  = pending_q | swap_req;
        wr_row_ext = 32'(wr_row);

        if (wr_en && (wr_row_ext < ROWS)) begin
            mem_d[~front_q][wr_row] = wr_data;
        end

        // The first clock edge after reset produces the outputs for SHIFT cycle 0.
        // For that edge the state is held instead of advanced.
        if (!started_q) begin
            started_d = 1'b1;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (cnt_q == CNT_W'(SHIFT_LEN - 1)) begin
                        state_d = ST_ROW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_ROW:   state_d = ST_LATCH;
                ST_LATCH: begin
                    state_d = ST_DISPLAY;
                    cnt_d   = '0;
                end
                default: begin
                    if (cnt_q == CNT_W'(DISP_LEN - 1)) begin
                        state_d = ST_SHIFT;
                        cnt_d   = '0;
                        if (row_q == RW'(ROWS - 1)) begin
                            row_d = '0;
                            // Frame boundary: the only point where the banks may exchange.
                            if (pending_d) begin
                                front_d   = ~front_q;
                                pending_d = 1'b0;
                                ack_d     = 1'b1;
                            end
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end

        if (state_d == ST_LATCH) begin
            bright_d = brightness;
        end

        // on_time = (brightness + 1) scaled to the dwell; full brightness covers all of DISPLAY.
        on_time = ON_W'(bright_d) + ON_W'(1);
        on_time = on_time << (SCREENTIMERWIDTH - BRIGHT_BITS);

        // Each column occupies two SHIFT cycles, so the column is cnt/2 counted down from the MSB.
        col_idx = CIW'(COLS - 1) - CIW'(cnt_d >> 1);

        // Outputs are computed from the next state so that they are registered in the same cycle that state is entered.
        csdi_d = (state_d == ST_SHIFT) ? mem_d[front_d][row_d][col_idx] : 1'b0;
        cclk_d = (state_d == ST_SHIFT) && cnt_d[0];
        rclk_d = (state_d == ST_ROW);
        le_d   = (state_d == ST_LATCH);
        fs_d   = (state_d == ST_LATCH) && (row_d == '0);
        rsdi_d = (row_d == '0);
        oeb_d  = !((state_d == ST_DISPLAY) && (32'(cnt_d) < 32'(on_time)));
    end

    always_ff @(posedge clk32mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_SHIFT;
            cnt_q     <= '0;
            row_q     <= '0;
            started_q <= 1'b0;
            front_q   <= 1'b0;
            pending_q <= 1'b0;
            bright_q  <= '0;
            mem_q     <= '0;
            rclk_q    <= 1'b0;
            rsdi_q    <= 1'b0;
            cclk_q    <= 1'b0;
            csdi_q    <= 1'b0;
            le_q      <= 1'b0;
            oeb_q     <= 1'b1;
            ack_q     <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            started_q <= started_d;
            front_q   <= front_d;
            pending_q <= pending_d;
            bright_q  <= bright_d;
            mem_q     <= mem_d;
            rclk_q    <= rclk_d;
            rsdi_q    <= rsdi_d;
            cclk_q    <= cclk_d;
            csdi_q    <= csdi_d;
            le_q      <= le_d;
            oeb_q     <= oeb_d;
            ack_q     <= ack_d;
            fs_q      <= fs_d;
        end
    end

    assign RCLK        = rclk_q;
    assign RSDI        = rsdi_q;
    assign CCLK        = cclk_q;
    assign CSDI        = csdi_q;
    assign LE          = le_q;
    assign OEB         = oeb_q;
    assign swap_ack    = ack_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_matrix_scan_driver.sv
// tb/tb_matrix_scan_driver.sv - directed self-checking bench for matrix_scan_driver
module tb_matrix_scan_driver;
    localparam int ROWS = 4, COLS = 4, STW = 4, BB = 2;
    localparam int ROWP = 2 * COLS + 2 + (1 << STW);
    localparam int FRAME = ROWS * ROWP;

    logic clk = 1'b0, reset_n = 1'b0, wr_en = 1'b0, swap_req = 1'b0;
    logic [1:0] wr_row = '0;
    logic [COLS-1:0] wr_data = '0;
    logic [BB-1:0] brightness = '0;
    logic swap_ack, frame_start, RCLK, RSDI, CCLK, CSDI, LE, OEB;

    matrix_scan_driver #(.ROWS(ROWS), .COLS(COLS), .SCREENTIMERWIDTH(STW), .BRIGHT_BITS(BB)) dut (
        .clk32mhz(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .swap_req(swap_req), .swap_ack(swap_ack), .brightness(brightness), .frame_start(frame_start),
        .RCLK(RCLK), .RSDI(RSDI), .CCLK(CCLK), .CSDI(CSDI), .LE(LE), .OEB(OEB)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;
    logic [COLS-1:0] pix [ROWS];
    int oeb_low [ROWS];
    int acks, ack_pos, fs_cnt, fs_pos, first_cclk, rclk_pos, le_pos, rsdi_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered with the outputs showing frame position 0; leaves at position 0 of the next frame.
    task automatic capture_frame(input int rq0, input int rq1, input int rq2,
                                 input int wpos, input logic [1:0] wrw, input logic [COLS-1:0] wdat);
        acks = 0; ack_pos = -1; fs_cnt = 0; fs_pos = -1;
        first_cclk = -1; rclk_pos = -1; le_pos = -1; rsdi_err = 0;
        for (int r = 0; r < ROWS; r++) begin
            pix[r] = '0;
            oeb_low[r] = 0;
        end
        for (int i = 0; i < FRAME; i++) begin
            int r;
            r = i / ROWP;
            if (CCLK === 1'b1) begin
                pix[r] = {pix[r][COLS-2:0], CSDI};
                if (first_cclk < 0) first_cclk = i;
            end
            if (OEB === 1'b0) oeb_low[r]++;
            if (swap_ack === 1'b1) begin acks++; ack_pos = i; end
            if (frame_start === 1'b1) begin fs_cnt++; fs_pos = i; end
            if (RCLK === 1'b1 && rclk_pos < 0) rclk_pos = i;
            if (LE === 1'b1 && le_pos < 0) le_pos = i;
            if (RSDI !== (r == 0)) rsdi_err++;
            swap_req = (i == rq0) || (i == rq1) || (i == rq2);
            wr_en    = (i == wpos);
            wr_row   = wrw;
            wr_data  = wdat;
            step();
        end
        swap_req = 1'b0;
        wr_en    = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_oeb", 32'(OEB), 1);
        check_eq("rst_outs", 32'({RCLK, RSDI, CCLK, CSDI, LE, swap_ack, frame_start}), 0);
        @(negedge clk) reset_n = 1'b1;
        step();

        // Frame A: write row 0 and request a swap; still shows the cleared bank.
        capture_frame(20, -1, -1, 5, 2'd0, 4'b1010);
        check_eq("first_cclk", first_cclk, 1);
        check_eq("rclk_pos", rclk_pos, 8);
        check_eq("le_pos", le_pos, 9);
        check_eq("fs_pos", fs_pos, 9);
        check_eq("fs_cnt", fs_cnt, 1);
        check_eq("rsdi_walk", rsdi_err, 0);
        check_eq("a_pix0", 32'(pix[0]), 0);
        check_eq("a_oeb_b0_r0", oeb_low[0], 4);
        check_eq("a_oeb_b0_r3", oeb_low[3], 4);
        check_eq("a_acks", acks, 0);

        brightness = 2'd3;
        capture_frame(-1, -1, -1, -1, 2'd0, '0);
        check_eq("b_acks", acks, 1);
        check_eq("b_ack_pos", ack_pos, 0);
        check_eq("b_pix0", 32'(pix[0]), 32'b1010);
        check_eq("b_pix1", 32'(pix[1]), 0);
        check_eq("b_oeb_b3_r0", oeb_low[0], 16);
        check_eq("b_oeb_b3_r2", oeb_low[2], 16);

        // Frame C: three requests merge; boundary write to row 2 lands in the new front.
        capture_frame(10, 40, 70, FRAME - 1, 2'd2, 4'b1111);
        check_eq("c_acks", acks, 0);
        check_eq("c_pix0", 32'(pix[0]), 32'b1010);

        // Frame D: request only in the boundary cycle.
        capture_frame(FRAME - 1, -1, -1, -1, 2'd0, '0);
        check_eq("d_acks_merged", acks, 1);
        check_eq("d_pix2", 32'(pix[2]), 32'b1111);
        check_eq("d_pix0", 32'(pix[0]), 0);

        capture_frame(-1, -1, -1, 30, 2'd1, 4'b0110);
        check_eq("e_acks_boundary", acks, 1);
        check_eq("e_ack_pos", ack_pos, 0);
        check_eq("e_pix0", 32'(pix[0]), 32'b1010);
        check_eq("e_pix2", 32'(pix[2]), 0);

        for (int f = 0; f < 3; f++) begin
            capture_frame(-1, -1, -1, -1, 2'd0, '0);
            check_eq("noswap_acks", acks, 0);
            check_eq("noswap_pix1", 32'(pix[1]), 0);
        end

        // Mid-frame reset during row-2 DISPLAY with a swap pending.
        for (int i = 0; i < 2 * ROWP + 15; i++) begin
            swap_req = (i == 5);
            step();
        end
        swap_req = 1'b0;
        check_eq("pre_rst_oeb", 32'(OEB), 0);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_rst_oeb", 32'(OEB), 1);
        check_eq("async_rst_outs", 32'({RCLK, RSDI, CCLK, CSDI, LE, swap_ack, frame_start}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        step();
        capture_frame(-1, -1, -1, -1, 2'd0, '0);
        check_eq("post_fs_pos", fs_pos, 9);
        check_eq("post_rsdi", rsdi_err, 0);
        check_eq("post_pix", 32'({pix[0], pix[1], pix[2], pix[3]}), 0);
        capture_frame(-1, -1, -1, -1, 2'd0, '0);
        check_eq("post_pending_lost", acks, 0);
        check_eq("post_pix0", 32'(pix[0]), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
